// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared state encodings and helpers for the program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam int c_INSTR_BIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        LD_HDR   = 3'd0,
        LD_LOAD  = 3'd1,
        LD_START = 3'd2,
        LD_RUN   = 3'd3,
        LD_ERR   = 3'd4
    } ld_state_t;

    // A header is unusable when it is empty or larger than the store.
    function automatic logic hdr_invalid(input logic [31:0] n, input int ib);
        logic [32:0] cap;
        cap = 33'd1 << ib;
        return (n == 32'd0) || ({1'b0, n} > cap);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles four accepted bytes, LSB first, into a 32-bit word.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_shift;

    // The completed word includes the byte being accepted this cycle.
    assign word       = {byte_in, r_shift[31:8]};
    assign word_valid = shift_en && (r_cnt == 2'd3);

    always_ff @(posedge CLK) begin
        if (!RST || clr) begin
            r_cnt   <= 2'd0;
            r_shift <= 32'd0;
        end else if (shift_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Loads a length-prefixed byte stream into instruction memory
//                and launches the processor.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_BIT = c_INSTR_BIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [INSTR_BIT-1:0] wr_addr,
    output logic [31:0]          wr_data,
    output logic                 St,
    input  logic                 done,
    output logic                 busy,
    output logic                 error
);

    localparam logic [INSTR_BIT:0] c_ONE = 1;

    ld_state_t            r_state;
    ld_state_t            w_next;
    logic [INSTR_BIT:0]   r_count;
    logic [INSTR_BIT:0]   r_idx;
    logic                 r_wr_en;
    logic [INSTR_BIT-1:0] r_wr_addr;
    logic [31:0]          r_wr_data;
    logic                 r_st;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_word_valid;
    logic [31:0]          w_word;
    logic                 w_hdr_ok;
    logic                 w_wr_fire;
    logic [INSTR_BIT:0]   w_idx_inc;

    assign w_in_ready = (r_state == LD_HDR) || (r_state == LD_LOAD);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_idx_inc  = r_idx + c_ONE;

    byte_packer u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (w_next != r_state),
        .shift_en   (w_xfer),
        .byte_in    (in_byte),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_comb begin
        w_next    = r_state;
        w_hdr_ok  = 1'b0;
        w_wr_fire = 1'b0;
        case (r_state)
            LD_HDR: begin
                if (w_word_valid) begin
                    if (hdr_invalid(w_word, INSTR_BIT)) begin
                        w_next = LD_ERR;
                    end else begin
                        w_hdr_ok = 1'b1;
                        w_next   = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                if (w_word_valid) begin
                    w_wr_fire = 1'b1;
                    if (w_idx_inc == r_count) begin
                        w_next = LD_START;
                    end
                end
            end
            LD_START: w_next = LD_RUN;
            LD_RUN: begin
                if (done) begin
                    w_next = LD_HDR;
                end
            end
            LD_ERR:  w_next = LD_ERR;
            default: w_next = LD_HDR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= LD_HDR;
            r_count   <= '0;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
            r_st      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_wr_fire;
            r_st    <= (r_state == LD_START);
            if (w_hdr_ok) begin
                // Legal N fits in INSTR_BIT+1 bits, so the upper bits are zero.
                r_count <= w_word[INSTR_BIT:0];
                r_idx   <= '0;
            end
            if (w_wr_fire) begin
                r_wr_addr <= r_idx[INSTR_BIT-1:0];
                r_wr_data <= w_word;
                r_idx     <= w_idx_inc;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign busy     = (r_state == LD_START) || (r_state == LD_RUN);
    assign error    = (r_state == LD_ERR);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign St       = r_st;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Directed self-checking bench for instr_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int IB = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_ready;
    logic          wr_en;
    logic [IB-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          St;
    logic          done = 1'b0;
    logic          busy;
    logic          error;

    int passes = 0;
    int total  = 0;

    int            cyc = 0;
    int            wr_cnt = 0;
    int            st_cnt = 0;
    int            last_wr_cyc = 0;
    int            st_cyc = 0;
    logic [IB-1:0] log_addr [64];
    logic [31:0]   log_data [64];

    int base_wr;
    int base_st;

    instr_loader #(.INSTR_BIT(IB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .St       (St),
        .done     (done),
        .busy     (busy),
        .error    (error)
    );

    always #5 CLK = ~CLK;

    // Observes what the memory and the processor controller would see.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            log_addr[wr_cnt[5:0]] <= wr_addr;
            log_data[wr_cnt[5:0]] <= wr_data;
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
        end
        if (St) begin
            st_cnt <= st_cnt + 1;
            st_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        in_valid = 1'b1;
        in_byte  = b;
        tick(1);
        if (gap) begin
            in_valid = 1'b0;
            tick(1);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send(w[7:0], gap);
        send(w[15:8], gap);
        send(w[23:16], gap);
        send(w[31:24], gap);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
        chk("rst_wr_addr",  {29'd0, wr_addr},  32'd0);
        chk("rst_wr_data",  wr_data,           32'd0);
        chk("rst_st",       {31'd0, St},       32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_error",    {31'd0, error},    32'd0);
        RST = 1'b1;
        tick(1);

        // Basic load, in_valid held high
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd2, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        in_valid = 1'b0;
        chk("basic_ready_low", {31'd0, in_ready}, 32'd0);
        tick(1);
        chk("basic_st_high", {31'd0, St},   32'd1);
        chk("basic_busy",    {31'd0, busy}, 32'd1);
        tick(3);
        chk("basic_wr_cnt",  wr_cnt - base_wr,          32'd2);
        chk("basic_a0",      {29'd0, log_addr[base_wr]}, 32'd0);
        chk("basic_d0",      log_data[base_wr],          32'h12345678);
        chk("basic_a1",      {29'd0, log_addr[base_wr+1]}, 32'd1);
        chk("basic_d1",      log_data[base_wr+1],        32'hDEADBEEF);
        chk("basic_st_cnt",  st_cnt - base_st,           32'd1);
        chk("basic_st_after_wr", st_cyc - last_wr_cyc,   32'd1);
        chk("basic_ready_run", {31'd0, in_ready},        32'd0);
        pulse_done();
        chk("basic_done_hdr", {31'd0, in_ready}, 32'd1);
        chk("basic_done_busy", {31'd0, busy},    32'd0);

        // in_valid gaps
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd2, 1'b1);
        send_word(32'h12345678, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        tick(4);
        chk("gap_wr_cnt", wr_cnt - base_wr,   32'd2);
        chk("gap_d0",     log_data[base_wr],   32'h12345678);
        chk("gap_a1",     {29'd0, log_addr[base_wr+1]}, 32'd1);
        chk("gap_d1",     log_data[base_wr+1], 32'hDEADBEEF);
        chk("gap_st_cnt", st_cnt - base_st,    32'd1);
        pulse_done();

        // Zero-length header
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd0, 1'b0);
        in_valid = 1'b0;
        done = 1'b1;
        tick(4);
        done = 1'b0;
        chk("zero_error",  {31'd0, error},    32'd1);
        chk("zero_ready",  {31'd0, in_ready}, 32'd0);
        chk("zero_no_wr",  wr_cnt - base_wr,  32'd0);
        chk("zero_no_st",  st_cnt - base_st,  32'd0);
        do_reset();
        chk("zero_rst_error", {31'd0, error},    32'd0);
        chk("zero_rst_ready", {31'd0, in_ready}, 32'd1);

        // Capacity + 1
        send_word(32'd9, 1'b0);
        in_valid = 1'b0;
        tick(1);
        chk("cap9_error", {31'd0, error}, 32'd1);
        do_reset();

        // Exactly at capacity
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd8, 1'b0);
        for (int i = 0; i < 8; i++) send_word(32'hA0000000 | i, 1'b0);
        in_valid = 1'b0;
        tick(4);
        chk("cap8_wr_cnt", wr_cnt - base_wr,           32'd8);
        chk("cap8_last_a", {29'd0, log_addr[base_wr+7]}, 32'd7);
        chk("cap8_last_d", log_data[base_wr+7],         32'hA0000007);
        chk("cap8_mid_d",  log_data[base_wr+4],         32'hA0000004);
        chk("cap8_st_cnt", st_cnt - base_st,            32'd1);
        chk("cap8_error",  {31'd0, error},              32'd0);
        pulse_done();

        // Reset mid-load after six data bytes
        send_word(32'd2, 1'b0);
        send_word(32'h44332211, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        in_valid = 1'b0;
        RST = 1'b0;
        tick(1);
        chk("mid_wr_data", wr_data,           32'd0);
        chk("mid_wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("mid_ready",   {31'd0, in_ready}, 32'd1);
        chk("mid_busy",    {31'd0, busy},     32'd0);
        RST = 1'b1;
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd1, 1'b0);
        send_word(32'h04030201, 1'b0);
        in_valid = 1'b0;
        tick(3);
        chk("mid_new_wr_cnt", wr_cnt - base_wr,           32'd1);
        chk("mid_new_a0",     {29'd0, log_addr[base_wr]}, 32'd0);
        chk("mid_new_d0",     log_data[base_wr],          32'h04030201);
        chk("mid_new_st",     st_cnt - base_st,           32'd1);
        pulse_done();

        // Spurious done in HDR and LOAD
        base_wr = wr_cnt; base_st = st_cnt;
        pulse_done();
        chk("spur_hdr_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'd1, 1'b0);
        in_valid = 1'b0;
        pulse_done();
        send(8'hCD, 1'b0);
        in_valid = 1'b0;
        pulse_done();
        send(8'hAB, 1'b0);
        send(8'h00, 1'b0);
        send(8'hF0, 1'b0);
        in_valid = 1'b0;
        tick(3);
        chk("spur_d0",   log_data[base_wr], 32'hF000ABCD);
        chk("spur_st",   st_cnt - base_st,  32'd1);
        chk("spur_busy", {31'd0, busy},     32'd1);

        // done held high through RUN, then another program
        done = 1'b1;
        tick(3);
        chk("held_hdr", {31'd0, in_ready}, 32'd1);
        base_wr = wr_cnt; base_st = st_cnt;
        send_word(32'd1, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        in_valid = 1'b0;
        tick(4);
        done = 1'b0;
        chk("held_d0", log_data[base_wr], 32'hCAFEF00D);
        chk("held_st", st_cnt - base_st,  32'd1);
        chk("held_back_hdr", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
